// File: rtl/wmem_pkg.sv
// Shared types for the weight-memory streamers: default geometry, derived widths,
// the streamed beat record and the read-sequencer state encoding.
package wmem_pkg;

  localparam int WMEM_DATA_W   = 16;
  localparam int WMEM_N_IN     = 8;
  localparam int WMEM_N_HIDDEN = 4;

  // Zero-width tags are avoided when a dimension collapses to a single entry
  localparam int ADDR_H_W = (WMEM_N_HIDDEN > 1) ? $clog2(WMEM_N_HIDDEN) : 1;
  localparam int ADDR_I_W = (WMEM_N_IN > 1) ? $clog2(WMEM_N_IN) : 1;
  localparam int RADDR_W  = (WMEM_N_HIDDEN * WMEM_N_IN > 1) ?
                            $clog2(WMEM_N_HIDDEN * WMEM_N_IN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_H_W-1:0] h;
    logic [ADDR_I_W-1:0] i;
    logic                last_row;
    logic                last;
  } tag_t;

  typedef struct packed {
    logic [WMEM_DATA_W-1:0] data;
    logic [ADDR_H_W-1:0]    h;
    logic [ADDR_I_W-1:0]    i;
    logic                   last_row;
    logic                   last;
  } beat_t;

  function automatic beat_t make_beat(input logic [WMEM_DATA_W-1:0] data, input tag_t tag);
    beat_t b;
    b.data     = data;
    b.h        = tag.h;
    b.i        = tag.i;
    b.last_row = tag.last_row;
    b.last     = tag.last;
    return b;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO of an arbitrary packed type with occupancy output; accepts a
// push while full as long as a pop happens in the same cycle.
module stream_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pushEn, popEn;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign popEn  = pop_i && (count_q != '0);
  assign pushEn = push_i && ((count_q != CNT_W'(DEPTH)) || popEn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) wptr_q <= nextPtr(wptr_q);
      if (popEn)  rptr_q <= nextPtr(rptr_q);
      count_q <= count_q + CNT_W'(pushEn) - CNT_W'(popEn);
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (pushEn) mem_q[wptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/wmem_hidden_streamer.sv
// Read-side sequencer for wmem_hidden: walks one row or the whole matrix and turns
// the 1-cycle synchronous read into a tagged valid/ready weight stream.
module wmem_hidden_streamer
  import wmem_pkg::*;
#(
  parameter int DATA_W   = WMEM_DATA_W,
  parameter int N_IN     = WMEM_N_IN,
  parameter int N_HIDDEN = WMEM_N_HIDDEN,
  parameter int FIFO_D   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     all_rows,
  input  logic [ADDR_H_W-1:0]      row_sel,
  output logic [RADDR_W-1:0]       raddr,
  input  logic [DATA_W-1:0]        rdata,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic signed [DATA_W-1:0] w_data,
  output logic [ADDR_H_W-1:0]      w_h,
  output logic [ADDR_I_W-1:0]      w_i,
  output logic                     w_last_row,
  output logic                     w_last,
  output logic                     busy,
  output logic                     done
);

  localparam int                  CNT_W  = $clog2(FIFO_D + 1);
  localparam logic [ADDR_I_W-1:0] LAST_I = ADDR_I_W'(N_IN - 1);
  localparam logic [ADDR_H_W-1:0] LAST_H = ADDR_H_W'(N_HIDDEN - 1);

  state_e              state_q, state_d;
  logic [ADDR_H_W-1:0] curH_q, curH_d, lastH_q, lastH_d;
  logic [ADDR_I_W-1:0] curI_q, curI_d;
  logic [RADDR_W-1:0]  raddr_q, raddr_d;
  logic                done_q, done_d;
  logic                s1Valid_q, s2Valid_q;
  tag_t                s1Tag_q, s2Tag_q;

  logic                issue, creditOk, popEn, headValid;
  logic [ADDR_H_W-1:0] issH, jobLastH;
  logic [ADDR_I_W-1:0] issI;
  tag_t                issTag;
  beat_t               headBeat;
  logic [CNT_W-1:0]    fifoCount;

  assign popEn = headValid && w_ready;

  // Reads in flight already own a FIFO slot, so issue only if the next one also fits
  assign creditOk = (int'(fifoCount) + int'(s1Valid_q) + int'(s2Valid_q) - int'(popEn)) < FIFO_D;

  always_comb begin
    state_d  = state_q;
    curH_d   = curH_q;
    curI_d   = curI_q;
    lastH_d  = lastH_q;
    raddr_d  = raddr_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    issH     = curH_q;
    issI     = curI_q;
    jobLastH = lastH_q;
    issTag   = '0;

    unique case (state_q)
      IDLE: begin
        issH     = all_rows ? '0 : row_sel;
        issI     = '0;
        jobLastH = all_rows ? LAST_H : row_sel;
        issue    = start;
      end
      ISSUE: issue = creditOk;
      DRAIN: begin
        if (popEn && headBeat.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    issTag.h        = issH;
    issTag.i        = issI;
    issTag.last_row = (issI == LAST_I);
    issTag.last     = (issI == LAST_I) && (issH == jobLastH);

    if (issue) begin
      raddr_d = RADDR_W'(issH) * RADDR_W'(N_IN) + RADDR_W'(issI);
      lastH_d = jobLastH;
      if (issTag.last_row) begin
        curI_d = '0;
        curH_d = issH + ADDR_H_W'(1);
      end else begin
        curI_d = issI + ADDR_I_W'(1);
        curH_d = issH;
      end
      state_d = issTag.last ? DRAIN : ISSUE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      curH_q  <= '0;
      curI_q  <= '0;
      lastH_q <= '0;
      raddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      curH_q  <= curH_d;
      curI_q  <= curI_d;
      lastH_q <= lastH_d;
      raddr_q <= raddr_d;
      done_q  <= done_d;
    end
  end

  // Tags shadow the address through the memory's read latency, independent of rdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
      s1Tag_q   <= '0;
      s2Tag_q   <= '0;
    end else begin
      s1Valid_q <= issue;
      s2Valid_q <= s1Valid_q;
      if (issue) s1Tag_q <= issTag;
      s2Tag_q <= s1Tag_q;
    end
  end

  stream_fifo #(
    .T     (beat_t),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s2Valid_q),
    .data_i  (make_beat(rdata, s2Tag_q)),
    .pop_i   (popEn),
    .data_o  (headBeat),
    .valid_o (headValid),
    .count_o (fifoCount)
  );

  assign raddr      = raddr_q;
  assign w_valid    = headValid;
  assign w_data     = headBeat.data;
  assign w_h        = headBeat.h;
  assign w_i        = headBeat.i;
  assign w_last_row = headBeat.last_row;
  assign w_last     = headBeat.last;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_wmem_hidden_streamer.sv
// Directed bench for wmem_hidden_streamer: a table of jobs with hand-computed
// endpoints plus a per-beat model, then a mid-job asynchronous reset sequence.
module tb_wmem_hidden_streamer;
  import wmem_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start, all_rows, w_ready;
  logic [1:0]        row_sel;
  logic [4:0]        raddr;
  logic [15:0]       rdata = '0;
  logic              w_valid, w_last_row, w_last, busy, done;
  logic signed [15:0] w_data;
  logic [1:0]        w_h;
  logic [2:0]        w_i;

  int total = 0;
  int bad   = 0;

  logic [15:0] memModel [32];

  typedef struct {
    bit          allRows;
    logic [1:0]  rowSel;
    int          readyMode;
    bit          restart;
    int          expBeats;
    logic [15:0] expFirst;
    logic [15:0] expLast;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] gotFirst, gotLast;

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= memModel[raddr];

  wmem_hidden_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .all_rows   (all_rows),
    .row_sel    (row_sel),
    .raddr      (raddr),
    .rdata      (rdata),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .w_h        (w_h),
    .w_i        (w_i),
    .w_last_row (w_last_row),
    .w_last     (w_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launches a job one cycle after the current one, so every job runs back-to-back
  task automatic applyStimulus(input bit allRows, input logic [1:0] rowSel);
    @(posedge clk); #1;
    checkOutput("idle_after_done", {29'd0, done, w_valid, busy}, 32'd0);
    start    = 1'b1;
    all_rows = allRows;
    row_sel  = rowSel;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic runJob(input int idx, input vec_t v, input int abortAt);
    int          k, c, stallLeft, firstValid, lastBeatCycle, doneCycle, nExp, expData;
    bit          rdy, holding, stableOk, busyOk, idleBad;
    logic [23:0] cur, held;
    logic [1:0]  eh, lastH;
    logic [2:0]  ei;
    nExp  = v.allRows ? 32 : 8;
    lastH = v.allRows ? 2'd3 : v.rowSel;
    applyStimulus(v.allRows, v.rowSel);
    k = 0; c = 0; stallLeft = 0; firstValid = -1; lastBeatCycle = -1; doneCycle = -1;
    holding = 1'b0; stableOk = 1'b1; busyOk = 1'b1; held = '0;
    while (c < 600 && doneCycle < 0) begin
      if (v.readyMode == 0) rdy = 1'b1;
      else rdy = (stallLeft == 0) && (c % 3 == 0);
      if (stallLeft > 0) stallLeft--;
      w_ready = rdy;
      if (v.restart && (c == 3 || c == 10)) begin
        start = 1'b1; all_rows = 1'b1; row_sel = 2'd0;
      end else begin
        start = 1'b0;
      end
      cur = {1'b0, w_data, w_h, w_i, w_last_row, w_last};
      if (holding && !(w_valid && cur == held)) stableOk = 1'b0;
      if (w_valid && firstValid < 0) firstValid = c;
      if (done) doneCycle = c;
      else if (!busy) busyOk = 1'b0;
      if (w_valid && rdy) begin
        eh = v.allRows ? 2'(k / 8) : v.rowSel;
        ei = 3'(k % 8);
        expData = int'(eh) * 10 + int'(ei) + 1;
        checkOutput($sformatf("job%0d_beat%0d", idx, k), 32'(cur),
                    {9'd0, 16'(expData), eh, ei, ei == 3'd7, (ei == 3'd7) && (eh == lastH)});
        if (k == 0) gotFirst = w_data;
        gotLast = w_data;
        lastBeatCycle = c;
        k++;
        if (v.readyMode == 2 && k == 5) stallLeft = 10;
        if (abortAt > 0 && k == abortAt) begin
          #3 rst = 1'b1;
          #1;
          checkOutput("reset_mid_job", {1'b0, w_valid, w_data, w_h, w_i, w_last_row, w_last, busy, done, raddr}, 32'd0);
          @(posedge clk); #2;
          rst = 1'b0; start = 1'b0; w_ready = 1'b1;
          idleBad = 1'b0;
          for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (w_valid || busy || done) idleBad = 1'b1;
          end
          checkOutput("post_reset_idle", 32'(idleBad), 32'd0);
          return;
        end
      end
      holding = w_valid && !rdy;
      held    = cur;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    checkOutput($sformatf("job%0d_done_seen", idx), 32'(doneCycle >= 0), 32'd1);
    checkOutput($sformatf("job%0d_beat_count", idx), k, v.expBeats);
    checkOutput($sformatf("job%0d_first_data", idx), 32'(gotFirst), 32'(v.expFirst));
    checkOutput($sformatf("job%0d_last_data", idx), 32'(gotLast), 32'(v.expLast));
    checkOutput($sformatf("job%0d_first_latency", idx), firstValid, 2);
    checkOutput($sformatf("job%0d_done_after_last", idx), doneCycle, lastBeatCycle + 1);
    checkOutput($sformatf("job%0d_busy_held", idx), 32'(busyOk), 32'd1);
    checkOutput($sformatf("job%0d_stall_stable", idx), 32'(stableOk), 32'd1);
    if (v.readyMode == 0)
      checkOutput($sformatf("job%0d_throughput", idx), lastBeatCycle, 2 + nExp - 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t abortJob, afterAbort;
    rst = 1'b1; start = 1'b0; all_rows = 1'b0; row_sel = 2'd0; w_ready = 1'b0;
    for (int h = 0; h < 4; h++)
      for (int i = 0; i < 8; i++)
        memModel[h * 8 + i] = 16'(h * 10 + i + 1);

    // allRows, rowSel, readyMode (0 always, 1 one-on-two-off, 2 plus stall), restart, beats, first, last
    vecs[0] = '{1'b0, 2'd2, 0, 1'b0, 8,  16'h0015, 16'h001C};
    vecs[1] = '{1'b1, 2'd0, 0, 1'b0, 32, 16'h0001, 16'h0026};
    vecs[2] = '{1'b0, 2'd0, 1, 1'b0, 8,  16'h0001, 16'h0008};
    vecs[3] = '{1'b0, 2'd3, 1, 1'b0, 8,  16'h001F, 16'h0026};
    vecs[4] = '{1'b1, 2'd0, 2, 1'b0, 32, 16'h0001, 16'h0026};
    vecs[5] = '{1'b0, 2'd1, 1, 1'b1, 8,  16'h000B, 16'h0012};
    abortJob   = '{1'b1, 2'd0, 0, 1'b0, 32, 16'h0001, 16'h0026};
    afterAbort = '{1'b0, 2'd0, 0, 1'b0, 8,  16'h0001, 16'h0008};

    #12;
    checkOutput("reset_state", {1'b0, w_valid, w_data, w_h, w_i, w_last_row, w_last, busy, done, raddr}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 6; n++) runJob(n, vecs[n], 0);

    runJob(6, abortJob, 12);
    runJob(7, afterAbort, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
